// File: rtl/alu_issue_ctrl.sv
// Issue controller for an 8-bit combinational ALU: accepts instructions, reads a 4x8 register
// file, drives the ALU for one cycle, writes back result and flags, then offers them downstream.
module alu_issue_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_instr,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_sel,
   input  logic [7:0]  alu_out,
   input  logic        alu_carry,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [7:0]  res_data,
   output logic        res_carry,
   output logic        res_zero,
   output logic [7:0]  retired
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_LOADI = 3'b111;

   logic [1:0] state_q, state_d;
   logic [7:0] rf_q [4];
   logic [7:0] rf_d [4];
   logic [7:0] alu_a_q, alu_a_d;
   logic [7:0] alu_b_q, alu_b_d;
   logic [2:0] alu_sel_q, alu_sel_d;
   logic [2:0] op_q, op_d;
   logic [1:0] rd_q, rd_d;
   logic [7:0] imm_q, imm_d;
   logic [7:0] res_data_q, res_data_d;
   logic       res_carry_q, res_carry_d;
   logic       res_zero_q, res_zero_d;
   logic [7:0] retired_q, retired_d;
   logic [7:0] wb_data;

   assign in_ready  = (state_q == IDLE) & ~rst;
   assign res_valid = (state_q == RESP);
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign res_data  = res_data_q;
   assign res_carry = res_carry_q;
   assign res_zero  = res_zero_q;
   assign retired   = retired_q;

   always_comb begin
      state_d     = state_q;
      rf_d        = rf_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      op_d        = op_q;
      rd_d        = rd_q;
      imm_d       = imm_q;
      res_data_d  = res_data_q;
      res_carry_d = res_carry_q;
      res_zero_d  = res_zero_q;
      retired_d   = retired_q;
      wb_data     = (op_q == OP_LOADI) ? imm_q : alu_out;

      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               op_d      = in_instr[15:13];
               rd_d      = in_instr[12:11];
               imm_d     = in_instr[7:0];
               alu_a_d   = rf_q[in_instr[10:9]];
               alu_b_d   = rf_q[in_instr[8:7]];
               alu_sel_d = in_instr[15:13];
               state_d   = EXEC;
            end
         end
         EXEC: begin
            rf_d[rd_q]  = wb_data;
            res_data_d  = wb_data;
            res_carry_d = (op_q == OP_ADD) ? alu_carry : 1'b0;
            res_zero_d  = (wb_data == 8'd0);
            state_d     = RESP;
         end
         RESP: begin
            if (res_ready) begin
               retired_d = retired_q + 8'd1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         for (int unsigned i = 0; i < 4; i++) rf_q[i] <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_sel_q   <= '0;
         op_q        <= '0;
         rd_q        <= '0;
         imm_q       <= '0;
         res_data_q  <= '0;
         res_carry_q <= 1'b0;
         res_zero_q  <= 1'b0;
         retired_q   <= '0;
      end else begin
         state_q     <= state_d;
         rf_q        <= rf_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         imm_q       <= imm_d;
         res_data_q  <= res_data_d;
         res_carry_q <= res_carry_d;
         res_zero_q  <= res_zero_d;
         retired_q   <= retired_d;
      end
   end

endmodule
